// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO pair.
// Shift-add multiply and restoring divide, one step per clock, on
// operand magnitudes; signs are reapplied in a single fix-up state.
//
// state | meaning
// IDLE  | waiting for a request; MTHI/MTLO written here
// MUL   | shift-add step per cycle, ITER cycles
// DIV   | restoring divide step per cycle, ITER cycles
// FIX   | sign correction / div-by-zero override, then HI/LO write
module muldiv_unit #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            Start,
    input  logic [5:0]      Funct,
    input  logic [XLEN-1:0] Rdata1,
    input  logic [XLEN-1:0] Rdata2,
    input  logic            Cancel,
    output logic            Busy,
    output logic            Done,
    output logic [XLEN-1:0] Hi,
    output logic [XLEN-1:0] Lo,
    output logic [XLEN-1:0] MfData
);
    localparam int CW = $clog2(ITER);

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    // MUL: {partial product, remaining multiplier}; DIV: {remainder, quotient/dividend}
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opa_q, opa_d;
    logic [XLEN-1:0]   orig_a_q, orig_a_d;
    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic              is_div_q, is_div_d;
    logic              neg_res_q, neg_res_d;
    logic              neg_rem_q, neg_rem_d;
    logic              div_zero_q, div_zero_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              is_div_req, is_signed_req, is_muldiv;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] acc_neg;

    // Decode the request and form operand magnitudes (0x80000000 maps to itself as unsigned)
    always_comb begin
        is_div_req    = (Funct == F_DIV) || (Funct == F_DIVU);
        is_signed_req = (Funct == F_MULT) || (Funct == F_DIV);
        is_muldiv     = is_signed_req || is_div_req || (Funct == F_MULTU);
        mag_a         = (is_signed_req && Rdata1[XLEN-1]) ? -Rdata1 : Rdata1;
        mag_b         = (is_signed_req && Rdata2[XLEN-1]) ? -Rdata2 : Rdata2;
    end

    // Single-step arithmetic for both algorithms and the negated accumulator
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opa_q : {XLEN{1'b0}})};
        div_shift = acc_q[2*XLEN-1:XLEN-1];
        div_diff  = div_shift - {1'b0, opa_q};
        acc_neg   = -acc_q;
    end

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opa_d      = opa_q;
        orig_a_d   = orig_a_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    if (is_muldiv) begin
                        state_d    = is_div_req ? S_DIV : S_MUL;
                        cnt_d      = '0;
                        acc_d      = {{XLEN{1'b0}}, (is_div_req ? mag_a : mag_b)};
                        opa_d      = is_div_req ? mag_b : mag_a;
                        orig_a_d   = Rdata1;
                        is_div_d   = is_div_req;
                        neg_res_d  = is_signed_req && (Rdata1[XLEN-1] ^ Rdata2[XLEN-1]);
                        neg_rem_d  = is_signed_req && Rdata1[XLEN-1];
                        div_zero_d = is_div_req && (Rdata2 == '0);
                    end else if (Funct == F_MTHI) begin
                        hi_d = Rdata2;
                    end else if (Funct == F_MTLO) begin
                        lo_d = Rdata2;
                    end
                end
            end
            S_MUL, S_DIV: begin
                if (Cancel) begin
                    state_d = S_IDLE;
                end else begin
                    if (state_q == S_MUL) begin
                        acc_d = {mul_sum, acc_q[XLEN-1:1]};
                    end else if (div_diff[XLEN]) begin
                        acc_d = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
                    end else begin
                        acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(ITER - 1)) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!Cancel) begin
                    done_d = 1'b1;
                    if (!is_div_q) begin
                        {hi_d, lo_d} = neg_res_q ? acc_neg : acc_q;
                    end else if (div_zero_q) begin
                        hi_d = orig_a_q;
                        lo_d = {XLEN{1'b1}};
                    end else begin
                        lo_d = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
                        hi_d = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opa_q      <= '0;
            orig_a_q   <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opa_q      <= opa_d;
            orig_a_q   <= orig_a_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // MFHI/MFLO read port, combinational on Funct
    always_comb begin
        case (Funct)
            F_MFHI:  MfData = hi_q;
            F_MFLO:  MfData = lo_q;
            default: MfData = '0;
        endcase
    end

    assign Busy = busy_q;
    assign Done = done_q;
    assign Hi   = hi_q;
    assign Lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed + light random bench for muldiv_unit with an expected-result queue.
module tb_muldiv_unit;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    logic        CLK = 1'b0;
    logic        RST;
    logic        Start;
    logic [5:0]  Funct;
    logic [31:0] Rdata1, Rdata2;
    logic        Cancel;
    logic        Busy, Done;
    logic [31:0] Hi, Lo, MfData;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    muldiv_unit #(.XLEN(32), .ITER(32)) dut (
        .CLK(CLK), .RST(RST), .Start(Start), .Funct(Funct),
        .Rdata1(Rdata1), .Rdata2(Rdata2), .Cancel(Cancel),
        .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo), .MfData(MfData)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one mult/div; optionally inject a request (or Cancel) at cycle inj_cyc.
    task automatic run_op(input string name, input logic [5:0] f,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input int inj_cyc, input logic [5:0] inj_f, input logic inj_cancel);
        int   cyc;
        exp_t e;
        if (!inj_cancel) sb.push_back('{hi: exp_hi, lo: exp_lo});
        @(negedge CLK);
        Start = 1'b1; Funct = f; Rdata1 = a; Rdata2 = b;
        @(negedge CLK);
        Start = 1'b0; Funct = F_MFHI;
        cyc = 1;
        check({name, "_busy_c1"}, {31'b0, Busy}, 32'd1);
        while (Done !== 1'b1 && cyc < 40) begin
            if (inj_cyc != 0 && cyc == inj_cyc) begin
                Start  = !inj_cancel;
                Funct  = inj_f;
                Rdata2 = 32'hDEADBEEF;
                Cancel = inj_cancel;
            end
            @(negedge CLK);
            cyc++;
            Start = 1'b0; Cancel = 1'b0; Funct = F_MFHI;
            if (inj_cyc != 0 && cyc == inj_cyc + 1) begin
                check({name, "_hold_hi"}, Hi, model_hi);
                check({name, "_hold_lo"}, Lo, model_lo);
                check({name, "_busy_after_inj"}, {31'b0, Busy}, {31'b0, !inj_cancel});
            end
            if (!inj_cancel && cyc == 33) check({name, "_busy_c33"}, {31'b0, Busy}, 32'd1);
        end
        if (inj_cancel) begin
            check({name, "_no_done"}, 32'(cyc), 32'd40);
            check({name, "_cancel_hi"}, Hi, model_hi);
            check({name, "_cancel_lo"}, Lo, model_lo);
        end else begin
            check({name, "_done_cycle"}, 32'(cyc), 32'd34);
            check({name, "_busy_c34"}, {31'b0, Busy}, 32'd0);
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL %s_sb observed=empty expected=entry", name);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({name, "_hi"}, Hi, e.hi);
                check({name, "_lo"}, Lo, e.lo);
                model_hi = e.hi;
                model_lo = e.lo;
            end
            @(negedge CLK);
            check({name, "_done_pulse"}, {31'b0, Done}, 32'd0);
        end
    endtask

    initial begin
        logic [31:0]     ra, rb;
        longint          ps;
        longint unsigned pu;
        int              sa, sb_i;

        RST = 1'b0; Start = 1'b0; Funct = F_MFHI; Rdata1 = '0; Rdata2 = '0; Cancel = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_hi", Hi, 32'h0);
        check("rst_lo", Lo, 32'h0);
        check("rst_busy", {31'b0, Busy}, 32'd0);
        check("rst_done", {31'b0, Done}, 32'd0);
        RST = 1'b1;

        run_op("multu_max", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0, F_MFHI, 1'b0);
        run_op("mult_neg", F_MULT, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 0, F_MFHI, 1'b0);
        Funct = F_MFHI; #1 check("mfhi", MfData, 32'hFFFFFFFF);
        Funct = F_MFLO; #1 check("mflo", MfData, 32'hFFFFFFF1);
        Funct = F_MULT; #1 check("mf_other", MfData, 32'h0);
        run_op("div_neg", F_DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, F_MFHI, 1'b0);
        run_op("divu", F_DIVU, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 0, F_MFHI, 1'b0);
        run_op("divu_zero", F_DIVU, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 0, F_MFHI, 1'b0);
        run_op("div_zero_neg", F_DIV, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 0, F_MFHI, 1'b0);
        run_op("div_wrap", F_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0, F_MFHI, 1'b0);
        run_op("mult_min", F_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0, F_MFHI, 1'b0);

        @(negedge CLK);
        Start = 1'b1; Funct = F_MTHI; Rdata2 = 32'h12345678;
        @(negedge CLK);
        Start = 1'b0; Funct = F_MFHI;
        check("mthi_hi", Hi, 32'h12345678);
        check("mthi_lo", Lo, model_lo);
        check("mthi_busy", {31'b0, Busy}, 32'd0);
        check("mthi_done", {31'b0, Done}, 32'd0);
        model_hi = 32'h12345678;

        run_op("mtlo_busy", F_MULT, 32'h00001234, 32'h00000010, 32'h00000000, 32'h00012340, 5, F_MTLO, 1'b0);
        run_op("div_cancel", F_DIV, 32'h00000064, 32'h00000007, 32'h0, 32'h0, 10, F_DIV, 1'b1);
        run_op("divu_after", F_DIVU, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 0, F_MFHI, 1'b0);

        for (int i = 0; i < 3; i++) begin
            ra = $urandom; rb = $urandom;
            if (rb == 0) rb = 32'd3;
            ps = longint'($signed(ra)) * longint'($signed(rb));
            run_op("rnd_mult", F_MULT, ra, rb, ps[63:32], ps[31:0], 0, F_MFHI, 1'b0);
            pu = {32'b0, ra} * {32'b0, rb};
            run_op("rnd_multu", F_MULTU, ra, rb, pu[63:32], pu[31:0], 0, F_MFHI, 1'b0);
            sa = $signed(ra); sb_i = $signed(rb);
            if (sb_i == -1) sb_i = 5;
            run_op("rnd_div", F_DIV, ra, 32'(sb_i), 32'(sa % sb_i), 32'(sa / sb_i), 0, F_MFHI, 1'b0);
            run_op("rnd_divu", F_DIVU, ra, rb, ra % rb, ra / rb, 0, F_MFHI, 1'b0);
        end

        @(negedge CLK);
        Start = 1'b1; Funct = F_MULT; Rdata1 = 32'd3; Rdata2 = 32'd4;
        @(negedge CLK);
        Start = 1'b0;
        repeat (19) @(negedge CLK);
        check("pre_rst_busy", {31'b0, Busy}, 32'd1);
        RST = 1'b0;
        #1;
        check("mid_rst_hi", Hi, 32'h0);
        check("mid_rst_lo", Lo, 32'h0);
        check("mid_rst_busy", {31'b0, Busy}, 32'd0);
        check("mid_rst_done", {31'b0, Done}, 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        repeat (3) @(negedge CLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
